// File: rtl/light_scene_ctrl.sv
// light_scene_ctrl
//
// Purpose:
//   Holds one brightness level per light and a window shade position. It
//   executes one-hot ON / OFF / FADE / SHADE commands taken through a
//   valid/ready handshake. FADE and SHADE ramp their target one step per
//   tick, where a tick is every TICK_DIV clock cycles. While a ramp is
//   running, no new commands are accepted.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   cmd_valid_i   command present
//   cmd_ready_o   high only while idle; a command is taken on valid && ready
//   tcode_i       one-hot opcode: 0001 ON, 0010 OFF, 0100 FADE, 1000 SHADE
//   ulight_i      target light index (ignored by SHADE)
//   lenght_i      level, fade target or shade target
//   wshade_o      current shade position
//   lightnum_o    index of the last accepted light command
//   lightstate_o  bit i set when light i has a non-zero level
//   level_o       packed levels, light i at [i*LVL_W +: LVL_W]
//   busy_o        a ramp is in progress
//   err_o         one-cycle pulse after a rejected command

module light_scene_ctrl #(
    parameter int NUM_LIGHTS = 16,
    parameter int IDX_W      = 4,
    parameter int LVL_W      = 4,
    parameter int TICK_DIV   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [3:0]                  tcode_i,
    input  logic [IDX_W-1:0]            ulight_i,
    input  logic [LVL_W-1:0]            lenght_i,
    output logic [LVL_W-1:0]            wshade_o,
    output logic [IDX_W-1:0]            lightnum_o,
    output logic [NUM_LIGHTS-1:0]       lightstate_o,
    output logic [NUM_LIGHTS*LVL_W-1:0] level_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int                TICK_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W:0]    LIGHT_LIMIT = (IDX_W + 1)'(NUM_LIGHTS);

    typedef enum logic [1:0] {
        IDLE,
        FADE,
        SHADE
    } state_e;

    state_e             state_q, state_d;
    logic [LVL_W-1:0]   level_q [NUM_LIGHTS];
    logic [LVL_W-1:0]   level_d [NUM_LIGHTS];
    logic [LVL_W-1:0]   wshade_q, wshade_d;
    logic [IDX_W-1:0]   lightnum_q, lightnum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LVL_W-1:0]   target_q, target_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               err_q, err_d;

    logic               cmdOneHot;
    logic               idxBad;
    logic               tickHit;
    logic [LVL_W-1:0]   rampCur;
    logic [LVL_W-1:0]   rampNext;

    // A valid opcode has exactly one bit set; x & (x-1) clears the lowest set bit.
    assign cmdOneHot = (tcode_i != 4'b0000) && ((tcode_i & (tcode_i - 4'd1)) == 4'b0000);
    assign idxBad    = {1'b0, ulight_i} >= LIGHT_LIMIT;
    assign tickHit   = (tick_q == TICK_LAST);

    // FADE and SHADE share one stepper. The stepper only runs while the
    // value differs from the target, so it cannot overshoot or wrap.
    assign rampCur  = (state_q == SHADE) ? wshade_q : level_q[idx_q];
    assign rampNext = (rampCur < target_q) ? rampCur + 1'b1 : rampCur - 1'b1;

    // Next-state logic. In IDLE a command is decoded or rejected. In FADE
    // and SHADE, the tick counter paces the steps. The ramp returns to IDLE
    // on the step that lands on the target.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        wshade_d   = wshade_q;
        lightnum_d = lightnum_q;
        idx_d      = idx_q;
        target_d   = target_q;
        tick_d     = tick_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (!cmdOneHot || (!tcode_i[3] && idxBad)) begin
                        err_d = 1'b1;
                    end else if (tcode_i[0]) begin
                        level_d[ulight_i] = (lenght_i == '0) ? '1 : lenght_i;
                        lightnum_d        = ulight_i;
                    end else if (tcode_i[1]) begin
                        level_d[ulight_i] = '0;
                        lightnum_d        = ulight_i;
                    end else if (tcode_i[2]) begin
                        idx_d      = ulight_i;
                        target_d   = lenght_i;
                        tick_d     = '0;
                        lightnum_d = ulight_i;
                        if (level_q[ulight_i] != lenght_i) begin
                            state_d = FADE;
                        end
                    end else begin
                        target_d = lenght_i;
                        tick_d   = '0;
                        if (wshade_q != lenght_i) begin
                            state_d = SHADE;
                        end
                    end
                end
            end
            FADE: begin
                if (tickHit) begin
                    tick_d         = '0;
                    level_d[idx_q] = rampNext;
                    if (rampNext == target_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            SHADE: begin
                if (tickHit) begin
                    tick_d   = '0;
                    wshade_d = rampNext;
                    if (rampNext == target_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset clears every level and aborts any ramp at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wshade_q   <= '0;
            lightnum_q <= '0;
            idx_q      <= '0;
            target_q   <= '0;
            tick_q     <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wshade_q   <= wshade_d;
            lightnum_q <= lightnum_d;
            idx_q      <= idx_d;
            target_q   <= target_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            for (int i = 0; i < NUM_LIGHTS; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    // Pack the level registers onto the output bus and decode the on bits.
    always_comb begin
        level_o      = '0;
        lightstate_o = '0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            level_o[i*LVL_W +: LVL_W] = level_q[i];
            lightstate_o[i]           = (level_q[i] != '0);
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign wshade_o    = wshade_q;
    assign lightnum_o  = lightnum_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_light_scene_ctrl.sv
// tb_light_scene_ctrl
//
// Purpose:
//   Directed scoreboard bench for light_scene_ctrl. The bench uses 12 lights,
//   which is not a power of two, so out-of-range indices can be rejected.
//   Each command pushes the output snapshots it should produce, along with
//   the cycle of each. A monitor pops one entry every time the DUT's visible
//   outputs change and compares both the value and the cycle.

module tb_light_scene_ctrl;

    localparam int NL = 12;
    localparam int IW = 4;
    localparam int LW = 4;
    localparam int TD = 8;

    localparam logic [3:0] OP_ON    = 4'b0001;
    localparam logic [3:0] OP_OFF   = 4'b0010;
    localparam logic [3:0] OP_FADE  = 4'b0100;
    localparam logic [3:0] OP_SHADE = 4'b1000;

    typedef struct packed {
        logic [NL*LW-1:0] lvl;
        logic [NL-1:0]    ls;
        logic [IW-1:0]    num;
        logic [LW-1:0]    shade;
        logic             busy;
        logic             err;
        logic             rdy;
    } snap_t;

    typedef struct {
        string name;
        int    cyc;
        snap_t s;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       tcode;
    logic [IW-1:0]    ulight;
    logic [LW-1:0]    lenght;
    logic [LW-1:0]    wshade;
    logic [IW-1:0]    lightnum;
    logic [NL-1:0]    lightstate;
    logic [NL*LW-1:0] level;
    logic             busy;
    logic             err;

    int    cyc         = 0;
    int    assertCount = 0;
    int    failCount   = 0;
    exp_t  expQ[$];

    logic [LW-1:0] mLevel [NL];
    logic [IW-1:0] mNum;
    logic [LW-1:0] mShade;

    string         rejName [5] = '{"rej_tcode_0011", "rej_tcode_0000", "rej_on_idx13",
                                   "rej_fade_idx12", "rej_tcode_1100"};
    logic [3:0]    rejTc   [5] = '{4'b0011, 4'b0000, OP_ON, OP_FADE, 4'b1100};
    logic [IW-1:0] rejUl   [5] = '{4'd1, 4'd1, 4'd13, 4'd12, 4'd0};
    logic [LW-1:0] rejLn   [5] = '{4'd3, 4'd3, 4'd5, 4'd2, 4'd1};

    light_scene_ctrl #(
        .NUM_LIGHTS (NL),
        .IDX_W      (IW),
        .LVL_W      (LW),
        .TICK_DIV   (TD)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .tcode_i      (tcode),
        .ulight_i     (ulight),
        .lenght_i     (lenght),
        .wshade_o     (wshade),
        .lightnum_o   (lightnum),
        .lightstate_o (lightstate),
        .level_o      (level),
        .busy_o       (busy),
        .err_o        (err)
    );

    // Free-running clock and a cycle counter that advances on each rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Build the expected snapshot from the current hand-set model values.
    task automatic pushExp(input string name, input int c, input logic b, input logic e);
        exp_t x;
        x.name    = name;
        x.cyc     = c;
        x.s       = '0;
        for (int i = 0; i < NL; i++) begin
            x.s.lvl[i*LW +: LW] = mLevel[i];
            x.s.ls[i]           = (mLevel[i] != '0);
        end
        x.s.num   = mNum;
        x.s.shade = mShade;
        x.s.busy  = b;
        x.s.err   = e;
        x.s.rdy   = !b;
        expQ.push_back(x);
    endtask

    // Present a command at a falling edge and wait, with a bound, until it is ready.
    // acc is the rising edge that accepts it.
    task automatic applyStimulus(input logic [3:0] tc, input logic [IW-1:0] ul,
                                 input logic [LW-1:0] ln, output int acc);
        int n;
        n         = 0;
        cmd_valid = 1'b1;
        tcode     = tc;
        ulight    = ul;
        lenght    = ln;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL ready_timeout at cycle %0d: cmd_ready=%b, required 1", cyc, cmd_ready);
        end
        acc = cyc + 1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput();
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL pending_expectations: %0d left, required 0 (next %s)",
                     expQ.size(), expQ[0].name);
        end
    endtask

    // Monitor: every change of the visible outputs must match the next
    // queued snapshot, and it must happen on the queued cycle.
    initial begin
        snap_t prevSnap;
        snap_t curSnap;
        exp_t  curExp;
        prevSnap = '0;
        forever begin
            @(negedge clk);
            curSnap.lvl   = level;
            curSnap.ls    = lightstate;
            curSnap.num   = lightnum;
            curSnap.shade = wshade;
            curSnap.busy  = busy;
            curSnap.err   = err;
            curSnap.rdy   = cmd_ready;
            if (curSnap != prevSnap) begin
                assertCount++;
                if (expQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL unexpected_change at cycle %0d: got %h, required no change",
                             cyc, curSnap);
                end else begin
                    curExp = expQ.pop_front();
                    if (curSnap != curExp.s || curExp.cyc != cyc) begin
                        failCount++;
                        $display("[TB] FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                                 curExp.name, curSnap, cyc, curExp.s, curExp.cyc);
                    end
                end
                prevSnap = curSnap;
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int hold;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        tcode     = '0;
        ulight    = '0;
        lenght    = '0;
        for (int i = 0; i < NL; i++) mLevel[i] = '0;
        mNum   = '0;
        mShade = '0;
        pushExp("reset_state", 1, 1'b0, 1'b0);
        waitCycles(3);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] ON/OFF back-to-back");
        applyStimulus(OP_ON, 4'd2, 4'd4, acc);
        mLevel[2] = 4'd4; mNum = 4'd2;
        pushExp("on_l2_lvl4", acc, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(OP_ON, 4'd5, 4'd0, acc);
        mLevel[5] = 4'd15; mNum = 4'd5;
        pushExp("on_l5_zero_is_full", acc, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(OP_OFF, 4'd2, 4'd0, acc);
        mLevel[2] = 4'd0; mNum = 4'd2;
        pushExp("off_l2", acc, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(OP_ON, 4'd2, 4'd4, acc);
        mLevel[2] = 4'd4;
        pushExp("on_l2_again", acc, 1'b0, 1'b0);
        nextCycle();

        $display("[TB] FADE 4->1 with a command held while busy");
        applyStimulus(OP_FADE, 4'd2, 4'd1, acc);
        pushExp("fade_start", acc, 1'b1, 1'b0);
        mLevel[2] = 4'd3;
        pushExp("fade_step1", acc + 8, 1'b1, 1'b0);
        mLevel[2] = 4'd2;
        pushExp("fade_step2", acc + 16, 1'b1, 1'b0);
        mLevel[2] = 4'd1;
        pushExp("fade_done", acc + 24, 1'b0, 1'b0);
        mLevel[7] = 4'd9; mNum = 4'd7;
        pushExp("held_cmd_accept", acc + 25, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(OP_ON, 4'd7, 4'd9, hold);
        nextCycle();

        $display("[TB] SHADE 0->4 then repeat");
        applyStimulus(OP_SHADE, 4'd14, 4'd4, acc);
        pushExp("shade_start", acc, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            mShade = LW'(k);
            pushExp($sformatf("shade_step%0d", k), acc + 8 * k, (k != 4), 1'b0);
        end
        nextCycle();
        waitCycles(33);
        applyStimulus(OP_SHADE, 4'd0, 4'd4, acc);
        nextCycle();
        waitCycles(3);

        $display("[TB] zero-distance FADE");
        applyStimulus(OP_FADE, 4'd5, 4'd15, acc);
        mNum = 4'd5;
        pushExp("fade_zero_dist", acc, 1'b0, 1'b0);
        nextCycle();
        waitCycles(1);

        $display("[TB] rejected commands");
        for (int r = 0; r < 5; r++) begin
            applyStimulus(rejTc[r], rejUl[r], rejLn[r], acc);
            pushExp({rejName[r], "_err"}, acc, 1'b0, 1'b1);
            pushExp({rejName[r], "_clear"}, acc + 1, 1'b0, 1'b0);
            nextCycle();
            waitCycles(1);
        end

        applyStimulus(OP_ON, 4'd11, 4'd2, acc);
        mLevel[11] = 4'd2; mNum = 4'd11;
        pushExp("on_last_light", acc, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(OP_OFF, 4'd2, 4'd0, acc);
        mLevel[2] = 4'd0; mNum = 4'd2;
        pushExp("off_l2_before_fade", acc, 1'b0, 1'b0);
        nextCycle();

        $display("[TB] reset during FADE 0->15");
        applyStimulus(OP_FADE, 4'd2, 4'd15, acc);
        pushExp("fade_up_start", acc, 1'b1, 1'b0);
        mLevel[2] = 4'd1;
        pushExp("fade_up_step1", acc + 8, 1'b1, 1'b0);
        mLevel[2] = 4'd2;
        pushExp("fade_up_step2", acc + 16, 1'b1, 1'b0);
        nextCycle();
        waitCycles(19);
        for (int i = 0; i < NL; i++) mLevel[i] = '0;
        mNum   = '0;
        mShade = '0;
        pushExp("reset_mid_fade", acc + 20, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        waitCycles(1);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(OP_ON, 4'd1, 4'd1, acc);
        mLevel[1] = 4'd1; mNum = 4'd1;
        pushExp("on_after_reset", acc, 1'b0, 1'b0);
        nextCycle();
        waitCycles(3);

        checkOutput();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/light_scene_ctrl.md
# light_scene_ctrl

Parametrised, clocked successor to the combinational lighting block. It holds a brightness level per light, executes ON/OFF/FADE/SHADE commands through a valid/ready handshake, and ramps levels and the window shade one step per tick. It sits between the home command decoder and the lamp/shade drivers. It exports per-light on bits, packed levels and the last addressed light number.

## Interface
- NUM_LIGHTS, 16, number of controlled lights (2..64)
- IDX_W, 4, width of light index; must satisfy 2**IDX_W >= NUM_LIGHTS
- LVL_W, 4, width of brightness, fade target and shade position
- TICK_DIV, 8, clock cycles per ramp step (>= 1)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready
- tcode  in  4  one-hot opcode: 0001 ON, 0010 OFF, 0100 FADE, 1000 SHADE
- ulight  in  IDX_W  target light index (ignored for SHADE)
- lenght  in  LVL_W  level / fade target / shade target
- wshade  out  LVL_W  current shade position
- lightnum  out  IDX_W  index of last accepted light command
- lightstate  out  NUM_LIGHTS  bit i = (level of light i != 0)
- level  out  NUM_LIGHTS*LVL_W  packed levels, light i at [i*LVL_W +: LVL_W]
- busy  out  1  ramp in progress
- err  out  1  one-cycle pulse on rejected command

## Operation
- States: IDLE, FADE, SHADE. cmd_ready = (state == IDLE). busy = !cmd_ready.
- ON: level[ulight] <= (lenght == 0) ? all-ones : lenght. Stays IDLE.
- OFF: level[ulight] <= 0. Stays IDLE.
- FADE: latch ulight and target = lenght, and clear the tick counter. If level[ulight] == target, stay IDLE with no change. Otherwise go to FADE.
- In FADE, each tick steps the level by +1 or -1 toward target. Return to IDLE on the tick that reaches target.
- SHADE: same as FADE, but acts on wshade and uses state SHADE. If wshade == lenght, stay IDLE.
- Tick: counter runs 0..TICK_DIV-1 in FADE/SHADE. A step occurs when the counter == TICK_DIV-1, then the counter wraps to 0.
- Rejects (err pulses, no other state change):
  - tcode not exactly one-hot, including 0000.
  - ulight >= NUM_LIGHTS for ON/OFF/FADE.
- lightnum <= ulight on every accepted, non-rejected ON/OFF/FADE. SHADE does not change lightnum.
- cmd_valid while busy: not accepted, no err, no effect. Holding it keeps it pending under the handshake.
- Other lights keep their levels during a fade. Only the latched index changes.
- Reset (asynchronous, any time, including mid-ramp):
  - state IDLE, all levels 0, wshade 0, lightnum 0, tick 0, err 0, busy 0.
  - Hence lightstate 0, level 0, cmd_ready 1.

## Timing
- Acceptance edge = rising edge at which cmd_valid && cmd_ready.
- ON/OFF: new level, lightstate and lightnum are visible right after the acceptance edge. cmd_ready stays 1, so back-to-back commands are accepted every cycle.
- err: high for exactly the cycle following the acceptance edge of a rejected command.
- FADE/SHADE with distance d = |target - current| > 0:
  - busy rises after the acceptance edge.
  - The k-th step lands on edge acceptance + k*TICK_DIV.
  - The final step lands at acceptance + d*TICK_DIV. busy falls and cmd_ready rises on that same edge.
  - The next command can be accepted on the following edge.
- Level arithmetic is unsigned LVL_W. Steps never overshoot, so wrap-around is impossible.
- All outputs are registered except cmd_ready, busy and lightstate, which decode directly from registers.

## Test plan
- Reset mid-fade: FADE light 2 from 0 to 15, then assert rst_n=0 at cycle 20 -> all outputs 0 immediately (asynchronous). After release, cmd_ready=1.
- ON/OFF:
  - ON ulight=2, lenght=4 -> level[11:8]=4, lightstate=16'h0004, lightnum=2 one cycle later.
  - ON ulight=5, lenght=0 -> level of light 5 = 15.
  - OFF 2 -> lightstate=16'h0020.
- Fade timing (TICK_DIV=8):
  - Light 2 at 4, FADE to 1 -> levels 3, 2, 1 at acceptance+8, +16, +24.
  - busy high for exactly 24 cycles.
  - cmd_valid held during busy is accepted at acceptance+25.
- SHADE: wshade 0, SHADE lenght=4 -> wshade 1..4 at +8/+16/+24/+32. lightnum unchanged. Then SHADE lenght=4 again -> no busy.
- Rejects:
  - tcode=0011 -> err 1 cycle, no change.
  - tcode=0000 -> err.
  - With NUM_LIGHTS=12, ON ulight=13 -> err, lightstate unchanged.
- Zero-distance FADE: FADE light 5 to its current level -> busy never asserts, cmd_ready stays 1, lightnum=5.
